// File: rtl/brent_kung_pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bk_pkg
// Brief    : Shared constants, log2 helper and prefix-pair type for the
//            pipelined Brent-Kung adder.
// Revision : 1.0
// ============================================================================
package bk_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int bk_log2(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) n = n + 1;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/brent_kung_pipe_adder_prefix_cell.sv
`default_nettype none
// ============================================================================
// Module   : bk_prefix_cell
// Brief    : Brent-Kung prefix operator; black cell (G,P) or grey cell (G only).
// Revision : 1.0
// ============================================================================
module bk_prefix_cell
  import bk_pkg::*;
#(
  parameter bit GREY = 1'b0
) (
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);

  if (GREY) begin : g_grey
    logic unused_lo_p;
    assign unused_lo_p = lo.p;
    assign o.p = 1'b0;
  end else begin : g_black
    assign o.p = hi.p & lo.p;
  end

endmodule
`default_nettype wire

// File: rtl/brent_kung_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : brent_kung_pipe_adder
// Brief    : 3-stage pipelined Brent-Kung add/subtract with valid/ready
//            handshakes and a sideband tag.
// Revision : 1.0
// ============================================================================
module brent_kung_pipe_adder
  import bk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic [TAG_W-1:0] In_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [TAG_W-1:0] Out_Tag
);

  localparam int LOG_W = bk_log2(WIDTH);

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             open1, open2, open3;
  logic [WIDTH-1:0] beff;

  logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
  logic             c0_1_q, c0_1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic [WIDTH-1:0] ug2_q, ug2_d, up2_q, up2_d, pb2_q, pb2_d;
  logic             c0_2_q, c0_2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic [WIDTH-1:0] up_g_root, up_p_root, dn_g_root;
  logic [WIDTH:0]   carry;
  logic             unused_up_p;

  // A stage may load when it is empty or its successor is taking its content.
  always_comb begin
    open3 = !v3_q || Out_Ready;
    open2 = !v2_q || open3;
    open1 = !v1_q || open2;
    v1_d  = open1 ? In_Valid : v1_q;
    v2_d  = open2 ? v1_q     : v2_q;
    v3_d  = open3 ? v2_q     : v3_q;
  end

  assign In_Ready = open1;

  always_comb begin
    beff   = (Sub == MODE_ADD) ? B : ~B;
    p1_d   = p1_q;
    g1_d   = g1_q;
    c0_1_d = c0_1_q;
    tag1_d = tag1_q;
    if (open1 && In_Valid) begin
      p1_d   = A ^ beff;
      g1_d   = A & beff;
      c0_1_d = (Sub == MODE_SUB) ? ~Cin : Cin;
      tag1_d = In_Tag;
    end
  end

  // Up-sweep; the carry-in is folded into bit 0 so every prefix includes it.
  for (genvar l = 0; l <= LOG_W; l++) begin : g_up
    logic [WIDTH-1:0] g, p;
    if (l == 0) begin : g_leaf
      assign g = {g1_q[WIDTH-1:1], g1_q[0] | (p1_q[0] & c0_1_q)};
      assign p = p1_q;
    end else begin : g_lvl
      localparam int SPAN = 1 << l;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % SPAN) == 0) begin : g_cell
          gp_t o;
          bk_prefix_cell #(.GREY(1'b0)) u_cell (
            .hi({g_up[l-1].g[i], g_up[l-1].p[i]}),
            .lo({g_up[l-1].g[i-SPAN/2], g_up[l-1].p[i-SPAN/2]}),
            .o (o)
          );
          assign g[i] = o.g;
          assign p[i] = o.p;
        end else begin : g_pass
          assign g[i] = g_up[l-1].g[i];
          assign p[i] = g_up[l-1].p[i];
        end
      end
    end
    if (l == LOG_W) begin : g_root
      assign up_g_root = g;
      assign up_p_root = p;
    end
  end

  always_comb begin
    ug2_d  = ug2_q;
    up2_d  = up2_q;
    pb2_d  = pb2_q;
    c0_2_d = c0_2_q;
    tag2_d = tag2_q;
    if (open2 && v1_q) begin
      ug2_d  = up_g_root;
      up2_d  = up_p_root;
      pb2_d  = p1_q;
      c0_2_d = c0_1_q;
      tag2_d = tag1_q;
    end
  end

  // Down-sweep: each non-prefix node is completed once by its nearest prefix.
  for (genvar k = 0; k < LOG_W; k++) begin : g_dn
    logic [WIDTH-1:0] g;
    if (k == 0) begin : g_base
      assign g = ug2_q;
    end else begin : g_lvl
      localparam int HALF = 1 << (LOG_W - k - 1);
      localparam int SPAN = 2 * HALF;
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (j >= HALF && ((j - HALF + 1) % SPAN) == 0) begin : g_cell
          gp_t  o;
          logic unused_p;
          bk_prefix_cell #(.GREY(1'b1)) u_cell (
            .hi({g_dn[k-1].g[j], up2_q[j]}),
            .lo({g_dn[k-1].g[j-HALF], 1'b0}),
            .o (o)
          );
          assign g[j]     = o.g;
          assign unused_p = o.p;
        end else begin : g_pass
          assign g[j] = g_dn[k-1].g[j];
        end
      end
    end
    if (k == LOG_W - 1) begin : g_root
      assign dn_g_root = g;
    end
  end

  assign carry       = {dn_g_root, c0_2_q};
  assign unused_up_p = ^up2_q;

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    tag3_d = tag3_q;
    if (open3 && v2_q) begin
      sum_d  = pb2_q ^ carry[WIDTH-1:0];
      cout_d = carry[WIDTH];
      ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
      tag3_d = tag2_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      tag3_q <= tag3_d;
    end
  end

  always_ff @(posedge Clk) begin
    p1_q   <= p1_d;
    g1_q   <= g1_d;
    c0_1_q <= c0_1_d;
    tag1_q <= tag1_d;
    ug2_q  <= ug2_d;
    up2_q  <= up2_d;
    pb2_q  <= pb2_d;
    c0_2_q <= c0_2_d;
    tag2_q <= tag2_d;
  end

  assign Out_Valid = v3_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Out_Tag   = tag3_q;

endmodule
`default_nettype wire

// File: tb/tb_brent_kung_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_brent_kung_pipe_adder
// Brief    : Self-checking bench for 16- and 64-bit pipelined adders.
// Revision : 1.0
// ============================================================================
module tb_brent_kung_pipe_adder;

  localparam int N_RND   = 3000;
  localparam int CYC_MAX = 60000;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [3:0]  tag;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic        cin      [2];
  logic        sub      [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic        cout     [2];
  logic        ovf      [2];
  logic [63:0] a        [2];
  logic [63:0] b        [2];
  logic [63:0] sum      [2];
  logic [3:0]  in_tag   [2];
  logic [3:0]  out_tag  [2];
  logic [15:0] sum16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  brent_kung_pipe_adder #(.WIDTH(16), .TAG_W(4)) dut16 (
    .Clk(Clk), .Rst(Rst), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
    .A(a[0][15:0]), .B(b[0][15:0]), .Cin(cin[0]), .Sub(sub[0]), .In_Tag(in_tag[0]),
    .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]), .Sum(sum16),
    .Cout(cout[0]), .Ovf(ovf[0]), .Out_Tag(out_tag[0])
  );
  assign sum[0] = {48'b0, sum16};

  brent_kung_pipe_adder #(.WIDTH(64), .TAG_W(4)) dut64 (
    .Clk(Clk), .Rst(Rst), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
    .A(a[1]), .B(b[1]), .Cin(cin[1]), .Sub(sub[1]), .In_Tag(in_tag[1]),
    .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]), .Sum(sum[1]),
    .Cout(cout[1]), .Ovf(ovf[1]), .Out_Tag(out_tag[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range test.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sb, input logic [3:0] tg);
    logic signed [67:0] one, mask, ua, ub, sa, sbv, cc, u, s, mx, mn;
    exp_t e;
    one  = 68'sd1;
    mask = (one <<< w) - one;
    ua   = {4'b0, av} & mask;
    ub   = {4'b0, bv} & mask;
    sa   = ua[w-1] ? ua - (one <<< w) : ua;
    sbv  = ub[w-1] ? ub - (one <<< w) : ub;
    cc   = ci ? one : 68'sd0;
    u    = sb ? ua - ub - cc : ua + ub + cc;
    s    = sb ? sa - sbv - cc : sa + sbv + cc;
    mx   = (one <<< (w - 1)) - one;
    mn   = -(one <<< (w - 1));
    e.sum  = 64'(u & mask);
    e.cout = sb ? (u >= 0) : (u > mask);
    e.ovf  = (s > mx) || (s < mn);
    e.tag  = tg;
    return e;
  endfunction

  function automatic logic [63:0] rnd_val(input int w);
    logic [63:0] m, r;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case ($urandom % 6)
      0:       r = 64'd0;
      1:       r = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       r = 64'd1 << (w - 1);
      3:       r = (64'd1 << (w - 1)) - 64'd1;
      default: r = {$urandom, $urandom};
    endcase
    return r & m;
  endfunction

  task automatic drive(input int d, input logic v, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb, input logic [3:0] tg);
    in_valid[d] = v;
    a[d]        = av;
    b[d]        = bv;
    cin[d]      = ci;
    sub[d]      = sb;
    in_tag[d]   = tg;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    @(negedge Clk);
    drive(0, 1'b1, {48'b0, v.a}, {48'b0, v.b}, v.cin, v.sub, v.tag);
    #1;
    check({nm, "_in_ready"}, in_ready[0], 1);
    @(negedge Clk);
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 8) begin
      @(negedge Clk);
      lat++;
    end
    check({nm, "_latency"}, lat, 3);
    check({nm, "_sum"}, sum[0], {48'b0, v.sum});
    check({nm, "_cout"}, cout[0], v.cout);
    check({nm, "_ovf"}, ovf[0], v.ovf);
    check({nm, "_tag"}, out_tag[0], v.tag);
    @(negedge Clk);
    check({nm, "_drained"}, out_valid[0], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    logic [63:0] bp_a[5], bp_b[5];
    logic        bp_c[5], bp_s[5];
    exp_t        bp_e[5];
    exp_t        q0[$], q1[$], e;
    int          idx, seen, cyc;
    int          issued[2];
    logic        acc[2];

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd1, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 4'd2, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 4'd4, 16'h0001, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 4'd5, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 4'd6, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 4'd7, 16'h5556, 1'b0, 1'b0};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 4'd8, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 4'd9, 16'h0000, 1'b1, 1'b1};

    Rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 4'd0);
      out_ready[d] = 1'b1;
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid[0], 0);
    check("rst_sum", sum[0], 0);
    check("rst_cout", cout[0], 0);
    check("rst_ovf", ovf[0], 0);
    check("rst_tag", out_tag[0], 0);
    check("rst_in_ready", in_ready[0], 1);
    check("rst_out_valid64", out_valid[1], 0);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Backpressure: three accepted, fourth held, then in-order drain.
    for (int t = 0; t < 5; t++) begin
      bp_a[t] = rnd_val(16);
      bp_b[t] = rnd_val(16);
      bp_c[t] = 1'($urandom);
      bp_s[t] = 1'($urandom);
      bp_e[t] = model(16, bp_a[t], bp_b[t], bp_c[t], bp_s[t], 4'(t));
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      out_ready[0] = 1'b0;
      if (idx < 5) drive(0, 1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 4'(idx));
      else in_valid[0] = 1'b0;
      #1;
      if (in_valid[0] && in_ready[0]) idx++;
      if (c >= 5) begin
        check("bp_stall_valid", out_valid[0], 1);
        check("bp_stall_sum", sum[0], bp_e[0].sum);
        check("bp_stall_tag", out_tag[0], 0);
      end
    end
    check("bp_accepted", idx, 3);
    check("bp_in_ready", in_ready[0], 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      out_ready[0] = 1'b1;
      if (idx < 5) drive(0, 1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 4'(idx));
      else in_valid[0] = 1'b0;
      #1;
      if (in_valid[0] && in_ready[0]) idx++;
      check($sformatf("bp_out%0d_valid", k), out_valid[0], 1);
      check($sformatf("bp_out%0d_sum", k), sum[0], bp_e[k].sum);
      check($sformatf("bp_out%0d_flags", k), {out_tag[0], cout[0], ovf[0]},
            {bp_e[k].tag, bp_e[k].cout, bp_e[k].ovf});
    end
    @(negedge Clk);
    in_valid[0] = 1'b0;
    check("bp_empty", out_valid[0], 0);

    // Reset with two ops in flight: neither may emerge.
    @(negedge Clk);
    drive(0, 1'b1, 64'h1111, 64'h2222, 1'b0, 1'b0, 4'd5);
    @(negedge Clk);
    drive(0, 1'b1, 64'h3333, 64'h4444, 1'b0, 1'b0, 4'd6);
    @(negedge Clk);
    in_valid[0] = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (out_valid[0]) seen++;
    end
    check("midrst_no_output", seen, 0);
    run_vec("post_rst", '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 4'd11, 16'h1001, 1'b0, 1'b0});

    // Random traffic on both widths with random backpressure.
    issued = '{0, 0};
    acc    = '{1'b0, 1'b0};
    cyc    = 0;
    while ((issued[0] < N_RND || issued[1] < N_RND || q0.size() != 0 || q1.size() != 0)
           && cyc < CYC_MAX) begin
      @(negedge Clk);
      cyc++;
      for (int d = 0; d < 2; d++) out_ready[d] = ($urandom % 4) != 0;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            check(d == 0 ? "rnd16_spurious" : "rnd64_spurious", 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check(d == 0 ? "rnd16_sum" : "rnd64_sum", sum[d], e.sum);
            check(d == 0 ? "rnd16_flags" : "rnd64_flags", {out_tag[d], cout[d], ovf[d]},
                  {e.tag, e.cout, e.ovf});
          end
        end
        if (in_valid[d] && !acc[d]) begin
          // held until accepted
        end else if (issued[d] < N_RND && ($urandom % 4) != 0) begin
          drive(d, 1'b1, rnd_val(d == 0 ? 16 : 64), rnd_val(d == 0 ? 16 : 64),
                1'($urandom), 1'($urandom), 4'($urandom));
        end else begin
          in_valid[d] = 1'b0;
        end
        acc[d] = in_valid[d] && in_ready[d];
        if (acc[d]) begin
          e = model(d == 0 ? 16 : 64, a[d], b[d], cin[d], sub[d], in_tag[d]);
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
          issued[d]++;
        end
      end
    end
    check("rnd_completed", cyc < CYC_MAX, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
